// File: rtl/l0_scaler_pkg.sv
// Shared sizing defaults and FSM state encodings for the L0 scaler gate/readout controller.
package l0_scaler_pkg;
  localparam int NCHAN_DEF    = 12;
  localparam int CNT_W_DEF    = 16;
  localparam int PERIOD_W_DEF = 24;

  typedef enum logic {G_OFF = 1'b0, G_RUN = 1'b1} gate_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rd_state_e;
endpackage

// File: rtl/l0_sat_counter.sv
// Per-channel saturating pulse counter; snap is the count including this cycle's pulse.
module l0_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] snap
);
  logic [CNT_W-1:0] cnt;

  assign snap = (inc && !(&cnt)) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= snap;
  end
endmodule

// File: rtl/l0_scaler_gate_ctrl.sv
// L0 scaler gating and bank readout controller. Optional macro L0_SCALER_GATE_SEQ_EN
// adds rd_seq_o, a per-bank gate sequence number.
module l0_scaler_gate_ctrl
  import l0_scaler_pkg::*;
#(
  parameter int NCHAN    = NCHAN_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk100_i,
  input  logic                rst_n_i,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [NCHAN-1:0]    pulse_i,
  output logic                gate_o,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [3:0]          rd_chan_o,
  output logic [CNT_W-1:0]    rd_count_o,
  output logic                rd_last_o,
`ifdef L0_SCALER_GATE_SEQ_EN
  output logic [7:0]          rd_seq_o,
`endif
  output logic                overrun_o
);
  localparam logic [3:0] LAST_IDX = 4'(NCHAN - 1);

  gate_state_e gstate;
  rd_state_e   rstate;

  logic [PERIOD_W-1:0]         tmr, tmr_init;
  logic [NCHAN-1:0][CNT_W-1:0] snap, shadow;
  logic [3:0]                  idx;
  logic gate_end, bank_busy, load, load_q, cnt_clr, ovr;

  assign tmr_init  = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1) : period_i - PERIOD_W'(1);
  assign gate_end  = (gstate == G_RUN) && enable_i && (tmr == '0);
  // load_q covers the cycle between the snapshot and R_SEND, so the bank counts as busy
  assign bank_busy = (rstate != R_IDLE) || load_q;
  assign load      = gate_end && !bank_busy;
  assign cnt_clr   = (gstate != G_RUN) || !enable_i || (tmr == '0);

  for (genvar n = 0; n < NCHAN; n++) begin : g_ch
    l0_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk100_i),
      .rst_n (rst_n_i),
      .inc   (pulse_i[n] && (gstate == G_RUN)),
      .clr   (cnt_clr),
      .snap  (snap[n])
    );
  end

  always_ff @(posedge clk100_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gstate <= G_OFF;
      tmr    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (gstate == G_OFF) begin
        if (enable_i) begin
          gstate <= G_RUN;
          tmr    <= tmr_init;
        end
      end else if (!enable_i) begin
        gstate <= G_OFF;
        tmr    <= '0;
      end else if (tmr == '0) begin
        tmr <= tmr_init;
      end else begin
        tmr <= tmr - PERIOD_W'(1);
      end

      if (!enable_i)                  ovr <= 1'b0;
      else if (gate_end && bank_busy) ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk100_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rstate <= R_IDLE;
      idx    <= '0;
      shadow <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= load;
      if (load) shadow <= snap;
      if (rstate == R_IDLE) begin
        idx <= '0;
        if (load_q) rstate <= R_SEND;
      end else if (rd_ready_i) begin
        if (idx == LAST_IDX) begin
          rstate <= R_IDLE;
          idx    <= '0;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

`ifdef L0_SCALER_GATE_SEQ_EN
  logic [7:0] seq_cnt, seq_q;

  // Dropped gates still advance the sequence so the consumer can see the gap
  always_ff @(posedge clk100_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seq_cnt <= '0;
      seq_q   <= '0;
    end else begin
      if ((gstate != G_RUN) || !enable_i) seq_cnt <= '0;
      else if (gate_end)                  seq_cnt <= seq_cnt + 8'd1;
      if (load) seq_q <= seq_cnt + 8'd1;
    end
  end

  assign rd_seq_o = seq_q;
`endif

  assign gate_o     = (gstate == G_RUN);
  assign overrun_o  = ovr;
  assign rd_valid_o = (rstate == R_SEND);
  assign rd_chan_o  = idx;
  assign rd_count_o = rd_valid_o ? shadow[idx] : '0;
  assign rd_last_o  = rd_valid_o && (idx == LAST_IDX);
endmodule

// File: tb/tb_l0_scaler_gate_ctrl.sv
// Directed bench for l0_scaler_gate_ctrl; expected banks are queued up front and checked as words drain.
module tb_l0_scaler_gate_ctrl;
  logic        clk100, rst_n, enable, rd_ready;
  logic [23:0] period;
  logic [11:0] pulse;
  logic        gate, rd_valid, rd_last, overrun;
  logic [3:0]  rd_chan;
  logic [15:0] rd_count;

  typedef struct {
    logic [3:0]  chan;
    logic [15:0] count;
    logic        last;
  } word_t;

  word_t sb[$];
  int    t0_q[$];
  int    checks, errors, cycn, c0;
  logic [11:0][15:0] bank;

  l0_scaler_gate_ctrl dut (
    .clk100_i   (clk100),
    .rst_n_i    (rst_n),
    .enable_i   (enable),
    .period_i   (period),
    .pulse_i    (pulse),
    .gate_o     (gate),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .rd_chan_o  (rd_chan),
    .rd_count_o (rd_count),
    .rd_last_o  (rd_last),
    .overrun_o  (overrun)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bank(input logic [11:0][15:0] v);
    word_t w;
    for (int i = 0; i < 12; i++) begin
      w.chan  = 4'(i);
      w.count = v[i];
      w.last  = (i == 11);
      sb.push_back(w);
    end
  endtask

  // Score the handshake of the current cycle, then advance one clock.
  task automatic cyc();
    word_t w;
    if (rd_valid && rd_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word: observed chan %0d count 0x%0h expected no word", rd_chan, rd_count);
      end
      if (sb.size() != 0) begin
        w = sb.pop_front();
        chk("word_chan",  32'(rd_chan),  32'(w.chan));
        chk("word_count", 32'(rd_count), 32'(w.count));
        chk("word_last",  32'(rd_last),  32'(w.last));
      end
      if (rd_chan == 4'd0) t0_q.push_back(cycn);
    end
    @(posedge clk100);
    #1;
    cycn++;
  endtask

  initial begin
    checks = 0; errors = 0; cycn = 0;
    rst_n = 1'b0; enable = 1'b0; period = '0; pulse = '0; rd_ready = 1'b1;
    repeat (3) @(posedge clk100);
    #1;
    chk("rst_gate",    32'(gate),     32'd0);
    chk("rst_valid",   32'(rd_valid), 32'd0);
    chk("rst_overrun", 32'(overrun),  32'd0);
    chk("rst_last",    32'(rd_last),  32'd0);
    chk("rst_count",   32'(rd_count), 32'd0);
    chk("rst_chan",    32'(rd_chan),  32'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Steady pulses on channel 3, period 100, three full banks
    period = 24'd100; pulse = 12'h008;
    bank = '0; bank[3] = 16'd100;
    repeat (3) push_bank(bank);
    t0_q.delete();
    enable = 1'b1; c0 = cycn;
    repeat (320) cyc();
    chk("t1_gate_open", 32'(gate), 32'd1);
    enable = 1'b0; pulse = '0;
    repeat (20) cyc();
    chk("t1_drained",   32'(sb.size()), 32'd0);
    chk("t1_banks",     32'(t0_q.size()), 32'd3);
    chk("t1_latency",   32'(t0_q[0] - c0), 32'd102);
    chk("t1_period_a",  32'(t0_q[1] - t0_q[0]), 32'd100);
    chk("t1_period_b",  32'(t0_q[2] - t0_q[1]), 32'd100);

    // Pulse only on the gate-end cycle lands in that bank, not the next
    period = 24'd20;
    bank = '0; bank[0] = 16'd1; push_bank(bank);
    bank = '0; push_bank(bank);
    enable = 1'b1;
    for (int k = 0; k < 56; k++) begin
      pulse = (k == 20) ? 12'h001 : 12'h000;
      cyc();
    end
    enable = 1'b0; pulse = '0;
    repeat (20) cyc();
    chk("t2_drained", 32'(sb.size()), 32'd0);

    // Saturation over a 70000-cycle gate
    period = 24'd70000; pulse = '1;
    for (int i = 0; i < 12; i++) bank[i] = 16'hFFFF;
    push_bank(bank);
    enable = 1'b1;
    repeat (70016) cyc();
    enable = 1'b0; pulse = '0;
    repeat (20) cyc();
    chk("t3_drained", 32'(sb.size()), 32'd0);

    // Stalled consumer across two gate ends
    period = 24'd20;
    bank = '0; bank[0] = 16'd20; bank[5] = 16'd20; push_bank(bank);
    enable = 1'b1;
    for (int k = 0; k < 78; k++) begin
      pulse    = (k <= 20) ? 12'h021 : 12'h080;
      rd_ready = (k >= 65);
      if (k == 30 || k == 41 || k == 50 || k == 61) begin
        chk("t4_hold_valid", 32'(rd_valid), 32'd1);
        chk("t4_hold_chan",  32'(rd_chan),  32'd0);
        chk("t4_hold_count", 32'(rd_count), 32'd20);
      end
      if (k == 45 || k == 77) chk("t4_overrun_set", 32'(overrun), 32'd1);
      cyc();
    end
    enable = 1'b0; pulse = '0;
    cyc();
    cyc();
    chk("t4_overrun_clr", 32'(overrun), 32'd0);
    rd_ready = 1'b1;
    repeat (20) cyc();
    chk("t4_drained", 32'(sb.size()), 32'd0);

    // Enable dropped mid-gate, then re-enabled
    period = 24'd100; pulse = 12'h004;
    bank = '0; bank[2] = 16'd100; push_bank(bank);
    t0_q.delete();
    enable = 1'b1; c0 = cycn;
    for (int k = 0; k < 200; k++) begin
      if (k == 50) enable = 1'b0;
      if (k == 60) enable = 1'b1;
      if (k == 49) chk("t5_gate_high", 32'(gate), 32'd1);
      if (k == 51) chk("t5_gate_low",  32'(gate), 32'd0);
      if (k == 55) chk("t5_overrun",   32'(overrun), 32'd0);
      if (k == 150) chk("t5_no_valid", 32'(rd_valid), 32'd0);
      cyc();
    end
    enable = 1'b0; pulse = '0;
    repeat (20) cyc();
    chk("t5_drained",  32'(sb.size()), 32'd0);
    chk("t5_banks",    32'(t0_q.size()), 32'd1);
    chk("t5_reenable", 32'(t0_q[0] - c0), 32'd162);

    // Reset in the middle of a readout
    period = 24'd20; pulse = 12'h800;
    bank = '0; bank[11] = 16'd20; push_bank(bank);
    enable = 1'b1;
    repeat (27) cyc();
    chk("t6_pre_valid", 32'(rd_valid), 32'd1);
    chk("t6_pre_chan",  32'(rd_chan),  32'd5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_gate",  32'(gate),     32'd0);
    chk("t6_rst_chan",  32'(rd_chan),  32'd0);
    chk("t6_rst_count", 32'(rd_count), 32'd0);
    sb.delete();
    enable = 1'b0; pulse = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (50) cyc();
    chk("t6_idle_valid", 32'(rd_valid), 32'd0);
    chk("t6_drained",    32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l0_scaler_gate_ctrl.md
Name: l0_scaler_gate_ctrl

Overview:
- Gating and readout controller for the 12 L0 scaler channels (TR,MR,BR,TR,MR,BR,TL,ML,BL,TL,ML,BL order).
- Counts the one-cycle scaler pulses in the clk100 domain over a programmable gate period.
- At each gate end, snapshots all 12 counts into a shadow bank and streams them out one channel per transfer on a valid/ready interface to the register/readout logic.

Parameters:
- NCHAN, 12, number of scaler channels.
- CNT_W, 16, per-channel count width; counts saturate.
- PERIOD_W, 24, width of the gate-period register, in clk100 cycles.

Ports:
- clk100_i  in  1  100 MHz clock; the only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  level; 1 = run gates, 0 = stop and clear.
- period_i  in  PERIOD_W  gate length in cycles; sampled at each gate start.
- pulse_i  in  NCHAN  scaler pulses, synchronous to clk100_i, any pattern per cycle.
- gate_o  out  1  high while a gate is open.
- rd_valid_o  out  1  current channel word is valid.
- rd_ready_i  in  1  consumer accepts the word when high together with rd_valid_o.
- rd_chan_o  out  4  channel index, 0..NCHAN-1.
- rd_count_o  out  CNT_W  latched count.
- rd_last_o  out  1  high with the channel NCHAN-1 word.
- overrun_o  out  1  sticky; a gate ended while the previous bank was still being read.

Behaviour:
- Reset: all outputs 0, counters 0, gate FSM in G_OFF, readout FSM in R_IDLE.
- Gate FSM, G_OFF:
  - Counters held at 0, gate_o=0.
  - On enable_i=1, load tmr=max(period_i,2)-1, go to G_RUN, gate_o=1 next cycle.
- Gate FSM, G_RUN:
  - Each cycle, every channel with pulse_i[n]=1 increments, saturating at 2^CNT_W-1.
  - tmr decrements each cycle.
  - When tmr==0 (gate-end cycle):
    - Snapshot value = counter + that cycle's pulse, saturated.
    - The snapshot goes to the shadow bank only if the readout FSM is R_IDLE. Otherwise the snapshot is dropped and overrun_o is set.
    - Counters clear to 0, tmr reloads from the current period_i.
    - gate_o stays high; gates are back-to-back with no dead cycle.
- enable_i falls mid-gate: next cycle goes to G_OFF, counters clear, the partial gate is discarded with no snapshot. overrun_o clears. An in-progress readout completes normally.
- Readout FSM:
  - R_IDLE: a snapshot load moves it to R_SEND with idx=0 on the following cycle.
  - R_SEND: rd_valid_o=1, rd_chan_o=idx, rd_count_o=shadow[idx], rd_last_o=(idx==NCHAN-1).
  - Outputs are stable while rd_ready_i=0.
  - On handshake, idx increments. A handshake with rd_last_o=1 returns to R_IDLE, rd_valid_o=0 next cycle.
- Latency: gate-end cycle T → first rd_valid_o at T+2.
- Minimum full-drain time is 12 cycles, so any period ≥ 14 with continuous rd_ready_i never overruns.
- Reset asserted mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: L0_SCALER_GATE_SEQ_EN.
- When defined:
  - Adds output rd_seq_o[7:0], an 8-bit gate sequence number.
  - Increments at every gate end, including dropped ones, and wraps 255→0.
  - Cleared in G_OFF and at reset.
  - Latched with the snapshot and held for all 12 words of that bank.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package l0_scaler_pkg: NCHAN, CNT_W, PERIOD_W defaults, and the gate-state and readout-state enums (G_OFF/G_RUN, R_IDLE/R_SEND).
- One sub-module, l0_sat_counter: CNT_W saturating counter with inc, clr and "value+inc" snapshot output, instantiated NCHAN times.

Test Plan:
- period_i=100, pulse_i[3] every cycle, rd_ready_i=1:
  - Word chan 3 count=100, all other channels 0, rd_last_o only on chan 11.
  - Words repeat every 100 cycles.
- Pulse on channel 0 exactly on the gate-end cycle only → that bank reports chan 0 = 1, next bank chan 0 = 0.
- CNT_W=16, period_i=70000, pulse_i=all ones → every channel reports 65535; no wrap to small values.
- rd_ready_i=0 held across two gate ends (period_i=20):
  - overrun_o=1, first bank words stay stable and unchanged.
  - After release, 12 words drain from the first bank.
- enable_i dropped at cycle 50 of a 100-cycle gate:
  - gate_o falls, no new rd_valid_o, overrun_o clears.
  - Re-enable gives the first bank a full 100 cycles later.
- Reset pulse during R_SEND at idx=5 → rd_valid_o=0 immediately; after reset no residual words are emitted.
